uart_baud_ctrl: RTL and testbench
=================================

Name: uart_baud_ctrl

Overview:
- Owns the UART baud divisor and generates the two baud ticks: tick16 (16x oversample) and tick1 (bit rate).
- Accepts divisor updates through a valid/ready handshake.
- Applies an update only when both TX and RX report idle, so no frame in flight ever sees a rate change mid-bit.
- Sits between the host config interface and the UART TX/RX engines, replacing a free-running mod-m tick source.

Parameters:
- WIDTH, 16, width of divisor and tick counter.
- DEFAULT_DIV, 26, divisor loaded at reset; tick16 period = DEFAULT_DIV+1 clocks (50 MHz / 115200 / 16).
- MIN_DIV, 1, smallest accepted divisor; smaller requests are clamped to this value.
- TIMEOUT_TICKS, 64, tick16 pulses to wait in PENDING before forcing the update (optional feature only).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, asynchronous active-low reset.
- enable, input, 1, tick generation enable; when low, counters hold.
- cfg_valid, input, 1, new divisor request.
- cfg_div, input, WIDTH, requested divisor (M; period = M+1).
- cfg_ready, output, 1, controller can accept a request.
- tx_busy, input, 1, TX engine mid-frame.
- rx_busy, input, 1, RX engine mid-frame.
- tick16, output, 1, one-cycle oversample tick.
- tick1, output, 1, one-cycle bit tick; coincides with every 16th tick16.
- div_active, output, WIDTH, divisor currently in use.
- pending, output, 1, an accepted request is awaiting application.
- cfg_forced, output, 1, one-cycle pulse when an update was forced by timeout; tied 0 without the optional feature.

Behaviour:
- Reset (async, rst=0) values:
  - state=RUN, div_active=DEFAULT_DIV, count=0, sub=0.
  - tick16=0, tick1=0, cfg_ready=1, pending=0, cfg_forced=0.
  - Any pending request is discarded.
- Tick counter (enable=1, not in APPLY):
  - If count==div_active, then count<=0 and tick16<=1 (registered); otherwise count<=count+1 and tick16<=0.
  - First tick16 lands DEFAULT_DIV+1 edges after reset release.
- Sub counter (4 bits): increments on each tick16 edge. tick1 is registered alongside tick16 when sub==15, so tick1 period = 16*(div_active+1).
- enable=0: count and sub hold; tick16 and tick1 drive 0; the config handshake still operates.
- State RUN:
  - cfg_ready=1.
  - On edge with cfg_valid=1: div_pending <= max(cfg_div, MIN_DIV); cfg_ready<=0; pending<=1; go to PENDING.
- State PENDING:
  - Tick generation continues with the old div_active.
  - Edge with tx_busy=0 and rx_busy=0 → APPLY. Busy lines are sampled in PENDING, never in the handshake cycle.
- State APPLY (one cycle):
  - At the exit edge: div_active<=div_pending, count<=0, sub<=0, tick16/tick1<=0, pending<=0, cfg_ready<=1; go to RUN.
- Latency: handshake edge E0 → APPLY at E1 (if idle) → new div_active visible after E2. Minimum 2 cycles with cfg_ready low. First tick16 at the new rate follows div_active+1 edges after E2.
- cfg_valid while cfg_ready=0 is ignored; no queueing, the requester must hold until the handshake.
- A request equal to the current divisor is still applied and restarts count/sub (used as a phase realign).
- WIDTH arithmetic: count wraps only via the compare, never by overflow. div_active=2^WIDTH-1 is legal.

Optional Feature:
- Macro UART_BAUD_TIMEOUT_EN.
- Defined:
  - A wait counter clears on PENDING entry and increments on each tick16 while in PENDING.
  - When it reaches TIMEOUT_TICKS with a busy line still high, go to APPLY anyway and pulse cfg_forced for the APPLY-exit cycle.
  - A normal idle-triggered apply has priority if both conditions hold on the same edge; cfg_forced stays 0 in that case.
- Undefined: PENDING waits indefinitely; no wait counter; cfg_forced is constant 0.

Test Plan:
- Reset release, enable=1, defaults → tick16 at edges 27, 54, 81…; tick1 first at edge 432, then every 432.
- tx_busy=rx_busy=0, cfg_div=53 handshake at E0 → cfg_ready low for 2 cycles, div_active=53 after E2, tick16 every 54 clocks from E2.
- tx_busy=1 for 1000 clocks then 0, cfg_div=13 → pending=1 and 27-clock ticks throughout busy; div_active=13 two edges after busy drops; cfg_forced=0 (macro undefined).
- cfg_div=0, MIN_DIV=1 → div_active=1; tick16 every 2 clocks; tick1 every 32.
- UART_BAUD_TIMEOUT_EN, TIMEOUT_TICKS=4, rx_busy stuck 1, cfg_div=40 → forced apply after 4th tick16 (~108 clocks); cfg_forced pulses once; div_active=40.
- rst pulsed low while in PENDING (cfg_div=99 accepted) → immediately div_active=26, pending=0, cfg_ready=1, ticks 0; after release, 27-clock period resumes.

Source files
------------

// File: rtl/uart_baud_ctrl.sv
// Baud divisor owner and 16x/1x tick generator with idle-gated divisor updates.
// Optional macro UART_BAUD_TIMEOUT_EN forces a pending update after TIMEOUT_TICKS tick16 pulses.
module uart_baud_ctrl #(
  parameter int WIDTH         = 16,
  parameter int DEFAULT_DIV   = 26,
  parameter int MIN_DIV       = 1,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             tx_busy,
  input  logic             rx_busy,
  output logic             tick16,
  output logic             tick1,
  output logic [WIDTH-1:0] div_active,
  output logic             pending,
  output logic             cfg_forced
);

  typedef enum logic [1:0] {RUN, PENDING, APPLY} state_t;

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] DEF_V = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] div_active_reg;
  logic [WIDTH-1:0] div_pending_reg;
  logic [3:0]       sub_reg;
  logic             tick16_reg;
  logic             tick1_reg;
  logic             idle;
  logic             force_apply;

  assign idle = !tx_busy && !rx_busy;

`ifdef UART_BAUD_TIMEOUT_EN
  logic [15:0] wait_reg;
  logic        forced_reg;
  logic        cfg_forced_reg;

  // Idle takes priority: force only while some engine is still busy.
  assign force_apply = (state_reg == PENDING) && !idle &&
                       (wait_reg == 16'(TIMEOUT_TICKS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_reg       <= '0;
      forced_reg     <= 1'b0;
      cfg_forced_reg <= 1'b0;
    end else begin
      if (state_reg != PENDING)
        wait_reg <= '0;
      else if (tick16_reg)
        wait_reg <= wait_reg + 16'd1;
      forced_reg     <= force_apply;
      cfg_forced_reg <= (state_reg == APPLY) && forced_reg;
    end
  end

  assign cfg_forced = cfg_forced_reg;
`else
  assign force_apply = 1'b0;
  assign cfg_forced  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= RUN;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (cfg_valid) state_next = PENDING;
      PENDING: if (idle || force_apply) state_next = APPLY;
      APPLY:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    cfg_ready  = (state_reg == RUN);
    pending    = (state_reg != RUN);
    tick16     = tick16_reg;
    tick1      = tick1_reg;
    div_active = div_active_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg       <= '0;
      sub_reg         <= 4'd0;
      tick16_reg      <= 1'b0;
      tick1_reg       <= 1'b0;
      div_active_reg  <= DEF_V;
      div_pending_reg <= DEF_V;
    end else begin
      if (state_reg == RUN && cfg_valid)
        div_pending_reg <= (cfg_div < MIN_V) ? MIN_V : cfg_div;

      // APPLY also restarts phase, so an unchanged divisor acts as a realign.
      if (state_reg == APPLY) begin
        div_active_reg <= div_pending_reg;
        count_reg      <= '0;
        sub_reg        <= 4'd0;
        tick16_reg     <= 1'b0;
        tick1_reg      <= 1'b0;
      end else if (enable) begin
        if (count_reg == div_active_reg) begin
          count_reg  <= '0;
          tick16_reg <= 1'b1;
          tick1_reg  <= (sub_reg == 4'hf);
          sub_reg    <= sub_reg + 4'd1;
        end else begin
          count_reg  <= count_reg + ONE_V;
          tick16_reg <= 1'b0;
          tick1_reg  <= 1'b0;
        end
      end else begin
        tick16_reg <= 1'b0;
        tick1_reg  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed self-checking bench for uart_baud_ctrl (default build, timeout feature off).
module tb_uart_baud_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic        tx_busy;
  logic        rx_busy;
  logic        tick16;
  logic        tick1;
  logic [15:0] div_active;
  logic        pending;
  logic        cfg_forced;

  int checks = 0;
  int errors = 0;

  uart_baud_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .tx_busy    (tx_busy),
    .rx_busy    (rx_busy),
    .tick16     (tick16),
    .tick1      (tick1),
    .div_active (div_active),
    .pending    (pending),
    .cfg_forced (cfg_forced)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; cfg_valid = 1'b0; cfg_div = 16'd0;
    tx_busy = 1'b0; rx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_tick16", tick16, 1'b0);
    chk1("rst_tick1", tick1, 1'b0);
    chk1("rst_ready", cfg_ready, 1'b1);
    chk1("rst_pending", pending, 1'b0);
    chk1("rst_forced", cfg_forced, 1'b0);
    chkw("rst_div", div_active, 16'd26);
    rst = 1'b1;

    // Default rate: tick16 every 27 edges, tick1 every 432.
    for (int e = 1; e <= 864; e++) begin
      step();
      chk1("def_tick16", tick16, (e % 27) == 0);
      chk1("def_tick1", tick1, (e % 432) == 0);
    end

    // Idle update to 53; a second request while not ready is ignored.
    cfg_div = 16'd53; cfg_valid = 1'b1;
    step();
    chk1("upd_e0_ready", cfg_ready, 1'b0);
    chk1("upd_e0_pending", pending, 1'b1);
    chk1("upd_e0_tick16", tick16, 1'b0);
    cfg_div = 16'd7;
    step();
    chk1("upd_e1_ready", cfg_ready, 1'b0);
    chk1("upd_e1_pending", pending, 1'b1);
    chkw("upd_e1_div", div_active, 16'd26);
    cfg_valid = 1'b0;
    step();
    chk1("upd_e2_ready", cfg_ready, 1'b1);
    chk1("upd_e2_pending", pending, 1'b0);
    chkw("upd_e2_div", div_active, 16'd53);
    chk1("upd_e2_tick16", tick16, 1'b0);
    for (int k = 1; k <= 108; k++) begin
      step();
      chk1("div53_tick16", tick16, (k % 54) == 0);
    end
    chkw("div53_hold", div_active, 16'd53);

    // Async reset while a request for 99 is pending.
    tx_busy = 1'b1; cfg_div = 16'd99; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk1("pend99_pending", pending, 1'b1);
    repeat (5) step();
    chk1("pend99_hold_pending", pending, 1'b1);
    chk1("pend99_hold_ready", cfg_ready, 1'b0);
    chkw("pend99_hold_div", div_active, 16'd53);
    #2 rst = 1'b0;
    #1;
    chkw("arst_div", div_active, 16'd26);
    chk1("arst_pending", pending, 1'b0);
    chk1("arst_ready", cfg_ready, 1'b1);
    chk1("arst_tick16", tick16, 1'b0);
    chk1("arst_tick1", tick1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Busy for 1000 clocks with a request for 13 waiting.
    cfg_div = 16'd13; cfg_valid = 1'b1;
    for (int e = 1; e <= 1000; e++) begin
      step();
      if (e == 1) cfg_valid = 1'b0;
      chk1("busy_tick16", tick16, (e % 27) == 0);
      chk1("busy_pending", pending, 1'b1);
      chk1("busy_forced", cfg_forced, 1'b0);
    end
    tx_busy = 1'b0;
    step();
    chk1("busy_e1_pending", pending, 1'b1);
    chkw("busy_e1_div", div_active, 16'd26);
    step();
    chkw("busy_e2_div", div_active, 16'd13);
    chk1("busy_e2_pending", pending, 1'b0);
    chk1("busy_e2_forced", cfg_forced, 1'b0);
    chk1("busy_e2_tick16", tick16, 1'b0);
    for (int k = 1; k <= 56; k++) begin
      step();
      chk1("div13_tick16", tick16, (k % 14) == 0);
    end

    // Divisor 0 clamps to MIN_DIV=1.
    cfg_div = 16'd0; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    chkw("clamp_div", div_active, 16'd1);
    for (int k = 1; k <= 70; k++) begin
      step();
      chk1("clamp_tick16", tick16, (k % 2) == 0);
      chk1("clamp_tick1", tick1, (k % 32) == 0);
    end

    // Same-divisor request realigns count and sub.
    cfg_div = 16'd1; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk1("realign_e0_tick16", tick16, 1'b0);
    step();
    chk1("realign_e1_tick16", tick16, 1'b1);
    step();
    chk1("realign_e2_tick16", tick16, 1'b0);
    chkw("realign_div", div_active, 16'd1);
    for (int k = 1; k <= 32; k++) begin
      step();
      chk1("realign_tick16", tick16, (k % 2) == 0);
      chk1("realign_tick1", tick1, k == 32);
    end

    // enable=0 silences ticks while the handshake still works.
    enable = 1'b0; cfg_div = 16'd5; cfg_valid = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 1) cfg_valid = 1'b0;
      chk1("dis_tick16", tick16, 1'b0);
      chk1("dis_tick1", tick1, 1'b0);
      if (e == 3) begin
        chkw("dis_div", div_active, 16'd5);
        chk1("dis_ready", cfg_ready, 1'b1);
      end
    end
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk1("en_tick16", tick16, (k % 6) == 0);
      chk1("en_tick1", tick1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
